// File: rtl/dsp_result_bank.sv
// dsp_result_bank: double-buffered, saturating result store between the DSP engines and EMIF readback.
module dsp_result_bank #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_IN_WIDTH  = 36,
    parameter int DATA_OUT_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      Mem2_we_i,
    input  logic [ADDR_WIDTH-1:0]     Mem2_addrw_i,
    input  logic [DATA_IN_WIDTH-1:0]  Mem2_data_i,
    input  logic                      WIP_flag_i,
    input  logic                      rd_en_i,
    input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
    input  logic                      clr_flags_i,
    output logic [DATA_OUT_WIDTH-1:0] rd_data_o,
    output logic                      rd_valid_o,
    output logic                      bank_o,
    output logic [15:0]               frame_cnt_o,
    output logic [15:0]               sat_cnt_o,
    output logic                      stray_o
);
    localparam int TOP_W = DATA_IN_WIDTH - DATA_OUT_WIDTH + 1;
    localparam logic [DATA_OUT_WIDTH-1:0] MAX_WORD = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic [DATA_OUT_WIDTH-1:0] MIN_WORD = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

    state_t                    state_q, state_d;
    logic                      bank_q, bank_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;
    logic [15:0]               sat_cnt_q, sat_cnt_d;
    logic                      stray_q, stray_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [DATA_OUT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_OUT_WIDTH-1:0] mem0 [2**ADDR_WIDTH];
    logic [DATA_OUT_WIDTH-1:0] mem1 [2**ADDR_WIDTH];
    logic [TOP_W-1:0]          top_bits;
    logic                      ovf, wr_ok, wr_bank;
    logic [DATA_OUT_WIDTH-1:0] wr_word, rd_word;

    // Clamp the incoming word to the readback range and qualify the write strobe.
    always_comb begin
        top_bits = Mem2_data_i[DATA_IN_WIDTH-1:DATA_OUT_WIDTH-1];
        ovf      = (|top_bits) && !(&top_bits);
        wr_word  = ovf ? (Mem2_data_i[DATA_IN_WIDTH-1] ? MIN_WORD : MAX_WORD)
                       : Mem2_data_i[DATA_OUT_WIDTH-1:0];
        wr_ok    = Mem2_we_i && WIP_flag_i;
    end

    // Next-state logic for the frame FSM, counters, sticky flags and read port.
    always_comb begin
        state_d     = state_q == IDLE ? (WIP_flag_i ? RUN : IDLE)
                    : state_q == RUN  ? (WIP_flag_i ? RUN : SWAP)
                    :                   (WIP_flag_i ? RUN : IDLE);
        bank_d      = state_q == SWAP ? !bank_q : bank_q;
        frame_cnt_d = frame_cnt_q + 16'(state_q == SWAP);
        sat_cnt_d   = clr_flags_i ? 16'(wr_ok && ovf)
                                  : sat_cnt_q + 16'(wr_ok && ovf && sat_cnt_q != 16'hFFFF);
        stray_d     = (Mem2_we_i && !WIP_flag_i) || (stray_q && !clr_flags_i);
        // During SWAP the bank about to become inactive is the next frame's write bank.
        wr_bank     = !bank_d;
        rd_word     = bank_q ? mem1[rd_addr_i] : mem0[rd_addr_i];
        rd_valid_d  = rd_en_i;
        rd_data_d   = rd_en_i ? rd_word : rd_data_q;
    end

    // Frame FSM and control registers; a reset mid-frame abandons the frame without swapping.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            bank_q      <= 1'b0;
            frame_cnt_q <= '0;
            sat_cnt_q   <= '0;
            stray_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            frame_cnt_q <= frame_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            stray_q     <= stray_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Result RAMs are not reset; writes are held off while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (wr_ok && rst_n_i) begin
            if (wr_bank) mem1[Mem2_addrw_i] <= wr_word;
            else         mem0[Mem2_addrw_i] <= wr_word;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign bank_o      = bank_q;
    assign frame_cnt_o = frame_cnt_q;
    assign sat_cnt_o   = sat_cnt_q;
    assign stray_o     = stray_q;
endmodule

// File: tb/tb_dsp_result_bank.sv
// tb_dsp_result_bank: randomized self-checking bench for dsp_result_bank against a frame-level model.
module tb_dsp_result_bank;
    logic        clk = 1'b0;
    logic        rst_n_i, Mem2_we_i, WIP_flag_i, rd_en_i, clr_flags_i;
    logic [8:0]  Mem2_addrw_i, rd_addr_i;
    logic [35:0] Mem2_data_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o, bank_o, stray_o;
    logic [15:0] frame_cnt_o, sat_cnt_o;

    dsp_result_bank dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .Mem2_we_i(Mem2_we_i), .Mem2_addrw_i(Mem2_addrw_i),
        .Mem2_data_i(Mem2_data_i), .WIP_flag_i(WIP_flag_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .clr_flags_i(clr_flags_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .bank_o(bank_o),
        .frame_cnt_o(frame_cnt_o), .sat_cnt_o(sat_cnt_o), .stray_o(stray_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: two frame images, which one the host sees, and the status counters.
    logic [31:0] mem [2][512];
    bit          known [2][512];
    int          mbank, mframe, msat;
    bit          mstray;
    logic [35:0] edges [4] = '{36'h0_7FFF_FFFF, 36'h0_8000_0000, 36'hF_8000_0000, 36'hF_7FFF_FFFF};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit over(input logic [35:0] d);
        longint v;
        v = $signed(d);
        return v > 64'sd2147483647 || v < -64'sd2147483648;
    endfunction

    function automatic logic [31:0] clamp(input logic [35:0] d);
        longint v;
        v = $signed(d);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return d[31:0];
    endfunction

    function automatic logic [35:0] rnd_data();
        logic [31:0] x;
        int          k;
        x = $urandom;
        k = $urandom_range(0, 3);
        if (k == 0) return {4'($urandom), x};
        if (k == 1) return {{4{x[31]}}, x};
        return edges[$urandom_range(0, 3)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One engine write cycle; clr_flags_i, if set by the caller, applies in the same cycle.
    task automatic wr(input int a, input logic [35:0] d);
        Mem2_we_i = 1'b1; Mem2_addrw_i = 9'(a); Mem2_data_i = d;
        if (clr_flags_i) begin mstray = 0; msat = 0; end
        if (WIP_flag_i) begin
            mem[1-mbank][a] = clamp(d);
            known[1-mbank][a] = 1;
            if (over(d) && msat < 65535) msat++;
        end else mstray = 1;
        tick();
        Mem2_we_i = 1'b0; clr_flags_i = 1'b0;
    endtask

    task automatic rd(input int a, input string tag);
        logic [31:0] e;
        bit          k;
        rd_en_i = 1'b1; rd_addr_i = 9'(a);
        e = mem[mbank][a]; k = known[mbank][a];
        tick();
        rd_en_i = 1'b0;
        check({tag, "_valid"}, rd_valid_o, 1);
        if (k) check(tag, rd_data_o, e);
    endtask

    task automatic end_frame(input string tag);
        WIP_flag_i = 1'b0;
        tick();
        tick();
        mbank = 1 - mbank;
        mframe = (mframe + 1) % 65536;
        check({tag, "_bank"}, bank_o, mbank);
        check({tag, "_frame"}, frame_cnt_o, mframe);
    endtask

    task automatic clear();
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        mstray = 0; msat = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_bank"}, bank_o, 0);
        check({tag, "_frame"}, frame_cnt_o, 0);
        check({tag, "_sat"}, sat_cnt_o, 0);
        check({tag, "_stray"}, stray_o, 0);
        check({tag, "_valid"}, rd_valid_o, 0);
        check({tag, "_data"}, rd_data_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] e;
        logic [35:0] b;
        rst_n_i = 1'b0; Mem2_we_i = 1'b0; WIP_flag_i = 1'b0; rd_en_i = 1'b0; clr_flags_i = 1'b0;
        Mem2_addrw_i = '0; rd_addr_i = '0; Mem2_data_i = '0;
        mbank = 0; mframe = 0; msat = 0; mstray = 0;
        foreach (known[i, j]) known[i][j] = 0;
        repeat (3) tick();
        reset_checks("rst");
        rst_n_i = 1'b1;
        tick();

        // Basic frame with in-range extremes.
        WIP_flag_i = 1'b1;
        wr(0, 36'h0_0000_0001); wr(1, 36'hF_FFFF_FFFF); wr(2, 36'h0_7FFF_FFFF); wr(3, 36'hF_8000_0000);
        end_frame("basic");
        rd(0, "basic_rd0"); check("basic_c0", rd_data_o, 32'h0000_0001);
        rd(1, "basic_rd1"); check("basic_c1", rd_data_o, 32'hFFFF_FFFF);
        rd(2, "basic_rd2"); check("basic_c2", rd_data_o, 32'h7FFF_FFFF);
        rd(3, "basic_rd3"); check("basic_c3", rd_data_o, 32'h8000_0000);
        tick();
        check("basic_pulse", rd_valid_o, 0);
        check("basic_hold", rd_data_o, 32'h8000_0000);
        check("basic_sat", sat_cnt_o, 0);

        // Random frames with reads of the exposed bank interleaved with writes.
        repeat (4) begin
            WIP_flag_i = 1'b1;
            for (int j = 0; j < 24; j++) begin
                if ($urandom_range(0, 3) == 0) rd($urandom_range(0, 15), "iso_rd");
                else wr($urandom_range(0, 15), rnd_data());
            end
            end_frame("rand");
            check("rand_sat", sat_cnt_o, msat);
            for (int a = 0; a < 16; a++) rd(a, "rand_rd");
        end

        // Saturation in both directions, then flag clear.
        clear();
        WIP_flag_i = 1'b1;
        wr(100, 36'h7_FFFF_FFFF); wr(101, 36'h8_0000_0000);
        end_frame("sat");
        rd(100, "sat_pos"); check("sat_pos_c", rd_data_o, 32'h7FFF_FFFF);
        rd(101, "sat_neg"); check("sat_neg_c", rd_data_o, 32'h8000_0000);
        check("sat_two", sat_cnt_o, 2);
        clear();
        check("sat_clr", sat_cnt_o, 0);

        // Stray write must not reach the write bank.
        WIP_flag_i = 1'b1; wr(400, 36'h0_1111_1111); end_frame("strayA");
        WIP_flag_i = 1'b1; wr(400, 36'h0_2222_2222); end_frame("strayB");
        wr(400, 36'h0_3333_3333);
        check("stray_set", stray_o, 1);
        tick();
        check("stray_sticky", stray_o, mstray);
        WIP_flag_i = 1'b1; wr(401, 36'h0_4444_4444); end_frame("strayC");
        rd(400, "stray_mem"); check("stray_mem_c", rd_data_o, 32'h1111_1111);
        check("stray_hold", stray_o, 1);
        clear();
        check("stray_clr", stray_o, 0);
        clr_flags_i = 1'b1; wr(402, 36'h0_5555_5555);
        check("stray_clr_coll", stray_o, 1);
        clear();
        WIP_flag_i = 1'b1; wr(403, 36'h0_0000_0007);
        clr_flags_i = 1'b1; wr(402, 36'h1_0000_0000);
        check("sat_clr_coll", sat_cnt_o, msat);
        check("sat_clr_coll1", sat_cnt_o, 1);
        end_frame("coll_pre");
        clear();

        // Swap collision: read on the SWAP edge and a WIP re-rise in the SWAP cycle.
        WIP_flag_i = 1'b1; wr(10, 36'h0_0000_0AAA); end_frame("swpP");
        WIP_flag_i = 1'b1; wr(10, 36'h0_0000_0BBB);
        WIP_flag_i = 1'b0;
        tick();
        check("swp_bank_pre", bank_o, mbank);
        e = mem[mbank][10];
        b = rnd_data();
        rd_en_i = 1'b1; rd_addr_i = 9'd10;
        WIP_flag_i = 1'b1; Mem2_we_i = 1'b1; Mem2_addrw_i = 9'd11; Mem2_data_i = b;
        mem[mbank][11] = clamp(b); known[mbank][11] = 1;
        if (over(b) && msat < 65535) msat++;
        mbank = 1 - mbank; mframe = (mframe + 1) % 65536;
        tick();
        rd_en_i = 1'b0; Mem2_we_i = 1'b0;
        check("swp_old_valid", rd_valid_o, 1);
        check("swp_old", rd_data_o, e);
        check("swp_old_c", rd_data_o, 32'h0000_0AAA);
        check("swp_bank", bank_o, mbank);
        rd(10, "swp_new"); check("swp_new_c", rd_data_o, 32'h0000_0BBB);
        wr(12, 36'h0_0000_0CCC);
        end_frame("swpR");
        rd(11, "swp_rerise");
        rd(12, "swp_next");
        check("swp_sat", sat_cnt_o, msat);

        // Single-cycle WIP pulse with no writes still swaps; then reset mid-frame with bank 1.
        WIP_flag_i = 1'b1; tick(); end_frame("pulse");
        if (mbank != 1) begin WIP_flag_i = 1'b1; tick(); end_frame("pulse2"); end
        WIP_flag_i = 1'b1;
        wr(20, 36'h0_0000_0123);
        check("midrst_pre", bank_o, 1);
        rst_n_i = 1'b0; WIP_flag_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        mbank = 0; mframe = 0; msat = 0; mstray = 0;
        reset_checks("midrst");
        tick(); tick();
        check("midrst_noswap", bank_o, 0);
        WIP_flag_i = 1'b1; wr(21, 36'h0_0000_0456); end_frame("postrst");
        check("postrst_bank1", bank_o, 1);
        check("postrst_frame1", frame_cnt_o, 1);
        rd(21, "postrst_rd");

        // Counter limits from a forced preload.
        force dut.frame_cnt_d = 16'hFFFF;
        tick();
        release dut.frame_cnt_d;
        mframe = 65535;
        check("frame_max", frame_cnt_o, 16'hFFFF);
        WIP_flag_i = 1'b1; tick(); end_frame("wrap");
        check("frame_wrap", frame_cnt_o, 0);
        force dut.sat_cnt_d = 16'hFFFE;
        tick();
        release dut.sat_cnt_d;
        msat = 65534;
        WIP_flag_i = 1'b1;
        wr(30, 36'h7_0000_0000);
        check("sat_max", sat_cnt_o, 16'hFFFF);
        wr(31, 36'h8_0000_0000); wr(32, 36'h4_0000_0000);
        check("sat_hold", sat_cnt_o, msat);
        check("sat_hold_c", sat_cnt_o, 16'hFFFF);
        end_frame("lim");
        rd(31, "lim_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
